line_fill_requester: RTL

//  clk_psram-side producer controller for the double-buffered video line store.
//  - Issues line_req/line_idx to the line generator and accepts its wr_addr/wr_data/wr_en beats.
//  - Writes the beats into the ping-pong line RAM and hands each completed line to the pixel domain.
//  - Runs on credits: the pixel domain returns a credit (toggle) each time it releases a bank.

---
 rtl/line_fill_requester.sv | 115 +++++++++++
 1 files changed

// File: rtl/line_fill_requester.sv
`timescale 1ns/1ps
// line_fill_requester: credit-driven producer that fills the ping-pong line RAM and hands completed lines to the pixel domain
module line_fill_requester #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 10,
  parameter int TIMEOUT  = 4095
) (
  input  logic              clk_psram,
  input  logic              rst_n,
  input  logic              pix_line_tgl,
  input  logic              pix_frame_tgl,
  output logic              line_req,
  output logic [ADDR_W-1:0] line_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              buf_we,
  output logic [ADDR_W:0]   buf_waddr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              fill_bank,
  output logic              line_ready_tgl,
  output logic [3:0]        err_flags
);
  localparam int CNT_W = $clog2(H_ACTIVE + 1);
  localparam int CYC_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] line_sync, frame_sync;
  logic [1:0] credits;
  logic [CNT_W-1:0] beat_cnt;
  logic [CYC_W-1:0] fill_cyc;
  logic line_ev, frame_ev, frame_pend, req_go, in_range, accept, last_beat, expired;
  assign line_ev  = line_sync[1] ^ line_sync[2];
  assign frame_ev = frame_sync[1] ^ frame_sync[2];
  // two-stage synchronizers plus an edge-detect stage for the pixel-domain toggles
  always_ff @(posedge clk_psram or negedge rst_n)
    if (!rst_n) begin
      line_sync  <= '0;
      frame_sync <= '0;
    end else begin
      line_sync  <= {line_sync[1:0], pix_line_tgl};
      frame_sync <= {frame_sync[1:0], pix_frame_tgl};
    end
  // state register
  always_ff @(posedge clk_psram or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: a credit starts a request; a fill ends on its last beat or on timeout
  always_comb
    state_nx = state == IDLE ? (credits != 2'd0 ? REQ : IDLE) :
               state == REQ  ? FILL :
               state == FILL ? (last_beat || expired ? DONE : FILL) : IDLE;
  // outputs and beat qualification decoded from the current state
  always_comb begin
    line_req  = state == REQ;
    req_go    = state == IDLE && credits != 2'd0;
    in_range  = 32'(wr_addr) < H_ACTIVE;
    accept    = state == FILL && wr_en && in_range;
    last_beat = accept && beat_cnt == CNT_W'(H_ACTIVE - 1);
    expired   = state == FILL && fill_cyc == CYC_W'(TIMEOUT - 1);
  end
  // fill progress: accepted beats and elapsed FILL cycles, restarted by each request
  always_ff @(posedge clk_psram or negedge rst_n)
    if (!rst_n) begin
      beat_cnt <= '0;
      fill_cyc <= '0;
    end else if (state == REQ) begin
      beat_cnt <= '0;
      fill_cyc <= '0;
    end else if (state == FILL) begin
      fill_cyc <= fill_cyc + 1'b1;
      if (accept) beat_cnt <= beat_cnt + 1'b1;
    end
  // write path: accepted beats land in the line RAM one cycle later in the bank being filled
  always_ff @(posedge clk_psram or negedge rst_n)
    if (!rst_n) begin
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
    end else begin
      buf_we <= accept;
      if (accept) begin
        buf_waddr <= {fill_bank, wr_addr};
        buf_wdata <= wr_data;
      end
    end
  // line handoff: a completed line toggles ready, swaps banks and advances (or restarts) the line index
  always_ff @(posedge clk_psram or negedge rst_n)
    if (!rst_n) begin
      line_ready_tgl <= 1'b0;
      fill_bank      <= 1'b0;
      line_idx       <= '0;
      frame_pend     <= 1'b0;
    end else if (state == DONE) begin
      line_ready_tgl <= ~line_ready_tgl;
      fill_bank      <= ~fill_bank;
      line_idx       <= (frame_pend || frame_ev || line_idx == ADDR_W'(V_ACTIVE - 1)) ? '0 : line_idx + 1'b1;
      frame_pend     <= 1'b0;
    end else if (frame_ev) frame_pend <= 1'b1;
  // credit pool (saturating at 2) and sticky error flags {timeout, credit_ovf, oob, stray}
  always_ff @(posedge clk_psram or negedge rst_n)
    if (!rst_n) begin
      credits   <= 2'd2;
      err_flags <= '0;
    end else begin
      credits   <= (line_ev && !req_go && credits != 2'd2) ? credits + 2'd1 :
                   (!line_ev && req_go) ? credits - 2'd1 : credits;
      err_flags <= err_flags | {expired && !last_beat,
                                line_ev && !req_go && credits == 2'd2,
                                state == FILL && wr_en && !in_range,
                                wr_en && state != FILL};
    end
endmodule
